// File: rtl/adxl362_pkg.sv
// rtl/adxl362_pkg.sv - shared ADXL362 instruction codes, register map and responder state encoding
package adxl362_pkg;

  localparam logic [7:0] INSTR_READ  = 8'h0B;
  localparam logic [7:0] INSTR_WRITE = 8'h0A;

  localparam logic [7:0] REG_DEVID_AD  = 8'h00;
  localparam logic [7:0] REG_DEVID_MST = 8'h01;
  localparam logic [7:0] REG_PARTID    = 8'h02;
  localparam logic [7:0] REG_STATUS    = 8'h0B;
  localparam logic [7:0] REG_XDATA_L   = 8'h0E;
  localparam logic [7:0] REG_XDATA_H   = 8'h0F;
  localparam logic [7:0] REG_YDATA_L   = 8'h10;
  localparam logic [7:0] REG_YDATA_H   = 8'h11;
  localparam logic [7:0] REG_ZDATA_L   = 8'h12;
  localparam logic [7:0] REG_ZDATA_H   = 8'h13;
  localparam logic [7:0] REG_POWER_CTL = 8'h2D;
  localparam logic [7:0] REG_ADDR_LAST = 8'h3F;

  localparam logic [7:0] DEVID_AD_VAL  = 8'hAD;
  localparam logic [7:0] DEVID_MST_VAL = 8'h1D;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INSTR,
    ST_ADDR,
    ST_RDATA,
    ST_WDATA,
    ST_IGNORE
  } resp_state_t;

  // Auto-increment pointer; the register space wraps at 0x3F.
  function automatic logic [7:0] next_addr(input logic [7:0] a);
    return (a == REG_ADDR_LAST) ? 8'h00 : a + 8'h01;
  endfunction

  function automatic logic is_axis_addr(input logic [7:0] a);
    return (a >= REG_XDATA_L) && (a <= REG_ZDATA_H);
  endfunction

endpackage

// File: rtl/spi_pin_sync.sv
// rtl/spi_pin_sync.sv - SPI pin synchronisers with sclk rise/fall and csn fall/rise strobes
module spi_pin_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rstn,
  input  logic sclk,
  input  logic mosi,
  input  logic csn,
  output logic sclk_rise,
  output logic sclk_fall,
  output logic mosi_s,
  output logic csn_s,
  output logic csn_fall,
  output logic csn_rise
);

  logic [SYNC_STAGES-1:0] sclk_q;
  logic [SYNC_STAGES-1:0] mosi_q;
  logic [SYNC_STAGES-1:0] csn_q;
  logic                   sclk_d;
  logic                   csn_d;

  // csn chain resets high so a deasserted select never looks like a falling edge.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sclk_q <= '0;
      mosi_q <= '0;
      csn_q  <= '1;
      sclk_d <= 1'b0;
      csn_d  <= 1'b1;
    end else begin
      sclk_q <= {sclk_q[SYNC_STAGES-2:0], sclk};
      mosi_q <= {mosi_q[SYNC_STAGES-2:0], mosi};
      csn_q  <= {csn_q[SYNC_STAGES-2:0], csn};
      sclk_d <= sclk_q[SYNC_STAGES-1];
      csn_d  <= csn_q[SYNC_STAGES-1];
    end
  end

  assign mosi_s    = mosi_q[SYNC_STAGES-1];
  assign csn_s     = csn_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_q[SYNC_STAGES-1] & ~sclk_d;
  assign sclk_fall = ~sclk_q[SYNC_STAGES-1] & sclk_d;
  assign csn_fall  = ~csn_q[SYNC_STAGES-1] & csn_d;
  assign csn_rise  = csn_q[SYNC_STAGES-1] & ~csn_d;

endmodule

// File: rtl/adxl362_responder.sv
// rtl/adxl362_responder.sv - ADXL362 register-interface SPI responder (mode 0, 0x0B burst read)
// Define ADXL362_RESP_WRITE_EN to accept 0x0A writes to POWER_CTL.
module adxl362_responder
  import adxl362_pkg::*;
#(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] PARTID      = 8'hF2,
  parameter int         COORD_WIDTH = 12
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   sclk,
  input  logic                   mosi,
  input  logic                   csn,
  output logic                   miso,
  output logic                   miso_oe,
  input  logic                   sample_valid,
  input  logic [COORD_WIDTH-1:0] x,
  input  logic [COORD_WIDTH-1:0] y,
  input  logic [COORD_WIDTH-1:0] z,
  output logic [7:0]             power_ctl,
  output logic                   busy
);

  if (COORD_WIDTH != 12) begin : g_bad_width
    $error("adxl362_responder: COORD_WIDTH must be 12");
  end

  logic sclk_rise, sclk_fall, mosi_s, csn_s, csn_fall, csn_rise;

  spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_pin_sync (
    .clk       (clk),
    .rstn      (rstn),
    .sclk      (sclk),
    .mosi      (mosi),
    .csn       (csn),
    .sclk_rise (sclk_rise),
    .sclk_fall (sclk_fall),
    .mosi_s    (mosi_s),
    .csn_s     (csn_s),
    .csn_fall  (csn_fall),
    .csn_rise  (csn_rise)
  );

  resp_state_t            state;
  logic [2:0]             bit_cnt;
  logic [6:0]             shreg;
  logic [7:0]             tx;
  logic [7:0]             addr_ptr;
  logic [7:0]             cur_addr;
  logic                   wr_mode;
  logic                   axis_read;
  logic                   data_ready;
  logic [COORD_WIDTH-1:0] x_r, y_r, z_r;
  logic [COORD_WIDTH-1:0] snap_x, snap_y, snap_z;
  logic [7:0]             rd_byte;

  assign busy = ~csn_s;

  always_comb begin
    rd_byte = 8'h00;
    case (addr_ptr)
      REG_DEVID_AD:  rd_byte = DEVID_AD_VAL;
      REG_DEVID_MST: rd_byte = DEVID_MST_VAL;
      REG_PARTID:    rd_byte = PARTID;
      REG_STATUS:    rd_byte = {7'd0, data_ready};
      REG_XDATA_L:   rd_byte = snap_x[7:0];
      REG_XDATA_H:   rd_byte = {{4{snap_x[11]}}, snap_x[11:8]};
      REG_YDATA_L:   rd_byte = snap_y[7:0];
      REG_YDATA_H:   rd_byte = {{4{snap_y[11]}}, snap_y[11:8]};
      REG_ZDATA_L:   rd_byte = snap_z[7:0];
      REG_ZDATA_H:   rd_byte = {{4{snap_z[11]}}, snap_z[11:8]};
      REG_POWER_CTL: rd_byte = power_ctl;
      default:       rd_byte = 8'h00;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= ST_IDLE;
      bit_cnt    <= 3'd0;
      shreg      <= 7'd0;
      tx         <= 8'h00;
      addr_ptr   <= 8'h00;
      cur_addr   <= 8'h00;
      wr_mode    <= 1'b0;
      axis_read  <= 1'b0;
      data_ready <= 1'b0;
      miso       <= 1'b0;
      miso_oe    <= 1'b0;
      power_ctl  <= 8'h00;
      x_r        <= '0;
      y_r        <= '0;
      z_r        <= '0;
      snap_x     <= '0;
      snap_y     <= '0;
      snap_z     <= '0;
    end else begin
      if (sample_valid) begin
        x_r <= x;
        y_r <= y;
        z_r <= z;
      end

      // A sample arriving with the select edge is the one the transaction sees.
      if (csn_fall) begin
        snap_x <= sample_valid ? x : x_r;
        snap_y <= sample_valid ? y : y_r;
        snap_z <= sample_valid ? z : z_r;
      end

      if (sample_valid)
        data_ready <= 1'b1;
      else if (csn_rise && axis_read)
        data_ready <= 1'b0;

      if (csn_rise) begin
        state     <= ST_IDLE;
        miso      <= 1'b0;
        miso_oe   <= 1'b0;
        axis_read <= 1'b0;
      end else if (csn_fall) begin
        state     <= ST_INSTR;
        bit_cnt   <= 3'd0;
        miso      <= 1'b0;
        miso_oe   <= 1'b0;
        axis_read <= 1'b0;
      end else begin
        case (state)
          ST_INSTR: if (sclk_rise) begin
            shreg   <= {shreg[5:0], mosi_s};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              case ({shreg, mosi_s})
                INSTR_READ: begin
                  state   <= ST_ADDR;
                  wr_mode <= 1'b0;
                end
`ifdef ADXL362_RESP_WRITE_EN
                INSTR_WRITE: begin
                  state   <= ST_ADDR;
                  wr_mode <= 1'b1;
                end
`else
                INSTR_WRITE: state <= ST_IGNORE;
`endif
                default: state <= ST_IGNORE;
              endcase
            end
          end

          ST_ADDR: if (sclk_rise) begin
            shreg   <= {shreg[5:0], mosi_s};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              addr_ptr <= {shreg, mosi_s};
              state    <= wr_mode ? ST_WDATA : ST_RDATA;
            end
          end

          ST_RDATA: begin
            if (sclk_fall) begin
              if (bit_cnt == 3'd0) begin
                miso     <= rd_byte[7];
                tx       <= {rd_byte[6:0], 1'b0};
                cur_addr <= addr_ptr;
                miso_oe  <= 1'b1;
              end else begin
                miso <= tx[7];
                tx   <= {tx[6:0], 1'b0};
              end
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7)
                addr_ptr <= next_addr(addr_ptr);
            end
            // The master samples the last bit of a byte on this rise.
            if (sclk_rise && bit_cnt == 3'd0 && miso_oe && is_axis_addr(cur_addr))
              axis_read <= 1'b1;
          end

`ifdef ADXL362_RESP_WRITE_EN
          ST_WDATA: if (sclk_rise) begin
            shreg   <= {shreg[5:0], mosi_s};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              if (addr_ptr == REG_POWER_CTL)
                power_ctl <= {shreg, mosi_s};
              addr_ptr <= next_addr(addr_ptr);
            end
          end
`endif

          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_adxl362_responder.sv
// tb/tb_adxl362_responder.sv - directed table-driven bench for adxl362_responder
module tb_adxl362_responder;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        sclk = 1'b0;
  logic        mosi = 1'b0;
  logic        csn = 1'b1;
  logic        sample_valid = 1'b0;
  logic [11:0] x = '0, y = '0, z = '0;
  logic        miso, miso_oe, busy;
  logic [7:0]  power_ctl;

  int tests = 0;
  int fails = 0;

  adxl362_responder dut (
    .clk          (clk),
    .rstn         (rstn),
    .sclk         (sclk),
    .mosi         (mosi),
    .csn          (csn),
    .miso         (miso),
    .miso_oe      (miso_oe),
    .sample_valid (sample_valid),
    .x            (x),
    .y            (y),
    .z            (z),
    .power_ctl    (power_ctl),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [7:0] addr;
    int         nbytes;
    logic [7:0] exp [6];
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic set_vec(input int i, input string n, input logic [7:0] a, input int nb,
                         input logic [7:0] e0, input logic [7:0] e1, input logic [7:0] e2,
                         input logic [7:0] e3, input logic [7:0] e4, input logic [7:0] e5);
    vecs[i].name   = n;
    vecs[i].addr   = a;
    vecs[i].nbytes = nb;
    vecs[i].exp[0] = e0; vecs[i].exp[1] = e1; vecs[i].exp[2] = e2;
    vecs[i].exp[3] = e3; vecs[i].exp[4] = e4; vecs[i].exp[5] = e5;
  endtask

  task automatic cs_low();
    @(negedge clk);
    csn = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic cs_high();
    csn = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  // Shifts nbits of b MSB first; miso is captured at each sclk rise like a mode-0 master.
  task automatic xfer(input logic [7:0] b, input int nbits, output logic [7:0] rx,
                      output logic oe_all, output logic oe_any);
    rx = 8'h00; oe_all = 1'b1; oe_any = 1'b0;
    for (int i = 7; i > 7 - nbits; i--) begin
      mosi = b[i];
      repeat (8) begin @(negedge clk); oe_any |= miso_oe; end
      sclk = 1'b1;
      rx[i] = miso;
      oe_all &= miso_oe;
      repeat (8) begin @(negedge clk); oe_any |= miso_oe; end
      sclk = 1'b0;
    end
  endtask

  task automatic read_txn(input string name, input logic [7:0] addr, input int nbytes,
                          input logic [7:0] exp [6]);
    logic [7:0] rx;
    logic oe_all, oe_any;
    cs_low();
    xfer(8'h0B, 8, rx, oe_all, oe_any);
    check({name, "_oe_instr"}, {7'd0, oe_any}, 8'h00);
    xfer(addr, 8, rx, oe_all, oe_any);
    check({name, "_oe_addr"}, {7'd0, oe_any}, 8'h00);
    for (int b = 0; b < nbytes; b++) begin
      xfer(8'h00, 8, rx, oe_all, oe_any);
      check($sformatf("%s_byte%0d", name, b), rx, exp[b]);
      check($sformatf("%s_oe%0d", name, b), {7'd0, oe_all}, 8'h01);
    end
    cs_high();
    check({name, "_oe_end"}, {6'd0, miso_oe, miso}, 8'h00);
  endtask

  task automatic pulse_sample(input logic [11:0] nx, input logic [11:0] ny, input logic [11:0] nz);
    @(negedge clk);
    x = nx; y = ny; z = nz; sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
  endtask

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] rx;
    logic       oe_all, oe_any;
    logic [7:0] e [6];
    logic [7:0] exp_pwr;

    set_vec(0, "id",        8'h00, 3, 8'hAD, 8'h1D, 8'hF2, 8'h00, 8'h00, 8'h00);
    set_vec(1, "status1",   8'h0B, 1, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    set_vec(2, "axis",      8'h0E, 6, 8'h23, 8'h01, 8'hFF, 8'hFF, 8'h00, 8'hF8);
    set_vec(3, "status0",   8'h0B, 1, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    set_vec(4, "wrap",      8'h3F, 2, 8'h00, 8'hAD, 8'h00, 8'h00, 8'h00, 8'h00);
    set_vec(5, "unmapped",  8'h20, 1, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    set_vec(6, "power_rd",  8'h2D, 1, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    set_vec(7, "y_only",    8'h10, 2, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00);

    repeat (4) @(negedge clk);
    check("rst_miso", {7'd0, miso}, 8'h00);
    check("rst_oe", {7'd0, miso_oe}, 8'h00);
    check("rst_power_ctl", power_ctl, 8'h00);
    check("rst_busy", {7'd0, busy}, 8'h00);
    rstn = 1'b1;
    repeat (4) @(negedge clk);

    pulse_sample(12'h123, 12'hFFF, 12'h800);

    for (int i = 0; i < 8; i++)
      read_txn(vecs[i].name, vecs[i].addr, vecs[i].nbytes, vecs[i].exp);

    // Coherence: new sample mid-read must not disturb the current snapshot.
    cs_low();
    check("busy_low", {7'd0, busy}, 8'h01);
    xfer(8'h0B, 8, rx, oe_all, oe_any);
    xfer(8'h0E, 8, rx, oe_all, oe_any);
    xfer(8'h00, 8, rx, oe_all, oe_any);
    check("coh_b0", rx, 8'h23);
    xfer(8'h00, 8, rx, oe_all, oe_any);
    check("coh_b1", rx, 8'h01);
    pulse_sample(12'h456, 12'h789, 12'hABC);
    e[0] = 8'hFF; e[1] = 8'hFF; e[2] = 8'h00; e[3] = 8'hF8;
    for (int b = 0; b < 4; b++) begin
      xfer(8'h00, 8, rx, oe_all, oe_any);
      check($sformatf("coh_b%0d", b + 2), rx, e[b]);
    end
    cs_high();
    e[0] = 8'h56; e[1] = 8'h04; e[2] = 8'h89; e[3] = 8'h07; e[4] = 8'hBC; e[5] = 8'hFA;
    read_txn("coh_next", 8'h0E, 6, e);
    e[0] = 8'h00;
    read_txn("coh_status", 8'h0B, 1, e);

    // sample_valid in the same cycle the synchronised csn falls: snapshot takes it.
    @(negedge clk);
    csn = 1'b0;
    x = 12'h00A; y = 12'h000; z = 12'h000;
    repeat (2) @(negedge clk);
    sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
    repeat (6) @(negedge clk);
    xfer(8'h0B, 8, rx, oe_all, oe_any);
    xfer(8'h0E, 8, rx, oe_all, oe_any);
    xfer(8'h00, 8, rx, oe_all, oe_any);
    check("same_cycle_xl", rx, 8'h0A);
    xfer(8'h00, 8, rx, oe_all, oe_any);
    check("same_cycle_xh", rx, 8'h00);
    cs_high();

    // Abort after 11 bits, then an unknown instruction.
    cs_low();
    xfer(8'h0B, 8, rx, oe_all, oe_any);
    xfer(8'h00, 3, rx, oe_all, oe_any);
    cs_high();
    check("abort_oe", {6'd0, miso_oe, miso}, 8'h00);
    cs_low();
    oe_all = 1'b0;
    for (int b = 0; b < 4; b++) begin
      xfer((b == 0) ? 8'h55 : 8'hFF, 8, rx, oe_all, oe_any);
      check($sformatf("bad_instr_oe%0d", b), {7'd0, oe_any}, 8'h00);
      check($sformatf("bad_instr_miso%0d", b), rx, 8'h00);
    end
    cs_high();
    // Abort mid data byte, then confirm normal service resumes.
    cs_low();
    xfer(8'h0B, 8, rx, oe_all, oe_any);
    xfer(8'h01, 8, rx, oe_all, oe_any);
    xfer(8'h00, 4, rx, oe_all, oe_any);
    check("abort_data_partial", rx, 8'h10);
    cs_high();
    check("abort_data_oe", {6'd0, miso_oe, miso}, 8'h00);
    e[0] = 8'hAD;
    read_txn("after_abort", 8'h00, 1, e);

    // Write to POWER_CTL.
`ifdef ADXL362_RESP_WRITE_EN
    exp_pwr = 8'h02;
`else
    exp_pwr = 8'h00;
`endif
    cs_low();
    xfer(8'h0A, 8, rx, oe_all, oe_any);
    xfer(8'h2D, 8, rx, oe_all, oe_any);
    xfer(8'h02, 8, rx, oe_all, oe_any);
    check("write_oe", {7'd0, oe_any}, 8'h00);
    cs_high();
    check("write_power_ctl", power_ctl, exp_pwr);
    e[0] = exp_pwr;
    read_txn("write_readback", 8'h2D, 1, e);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
